// File: rtl/ibuf_multi_pkg.sv
// Shared definitions for the multi-lane instruction buffer:
// exception codes and the stored entry layout.
package ibuf_multi_pkg;

   typedef enum logic [3:0] {
      NONE = 4'd0,
      INT  = 4'd1,
      ADEF = 4'd2,
      ALE  = 4'd3,
      SYS  = 4'd4,
      BRK  = 4'd5,
      INE  = 4'd6,
      IPE  = 4'd7
   } exception_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        pred_taken;
      logic [31:0] pred_target;
      logic        have_exc;
      exception_t  exc_type;
   } ibuf_entry_t;

endpackage

// File: rtl/ibuf_multi.sv
// In-order circular instruction buffer between fetch and decode: up to IN_WIDTH
// writes and OUT_WIDTH reads per cycle, clamped consume and sticky overflow.
module ibuf_multi
   import ibuf_multi_pkg::*;
#(
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned IN_WIDTH  = 2,
   parameter int unsigned OUT_WIDTH = 2,
   parameter int unsigned SKID      = 1
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 flush,
   input  logic                                 interrupt,
   input  logic [$clog2(IN_WIDTH+1)-1:0]        in_count,
   output logic                                 in_ready,
   input  logic [IN_WIDTH-1:0][31:0]            in_pc,
   input  logic [IN_WIDTH-1:0][31:0]            in_inst,
   input  logic [IN_WIDTH-1:0][31:0]            in_pred_target,
   input  logic [IN_WIDTH-1:0]                  in_pred_taken,
   input  logic [IN_WIDTH-1:0]                  in_have_exc,
   input  exception_t [IN_WIDTH-1:0]            in_exc_type,
   output logic [OUT_WIDTH-1:0]                 out_valid,
   output logic [OUT_WIDTH-1:0][31:0]           out_pc,
   output logic [OUT_WIDTH-1:0][31:0]           out_inst,
   output logic [OUT_WIDTH-1:0][31:0]           out_pred_target,
   output logic [OUT_WIDTH-1:0]                 out_pred_taken,
   output logic [OUT_WIDTH-1:0]                 out_have_exc,
   output exception_t [OUT_WIDTH-1:0]           out_exc_type,
   input  logic [$clog2(OUT_WIDTH+1)-1:0]       consume,
   output logic [$clog2(DEPTH+1)-1:0]           count,
   output logic                                 overflow
);

   localparam int unsigned PW        = $clog2(DEPTH);
   localparam int unsigned CW        = $clog2(DEPTH+1);
   localparam int unsigned READY_LIM = DEPTH - IN_WIDTH * (SKID + 1);

   typedef logic [PW-1:0] ptr_t;
   typedef logic [CW-1:0] cnt_t;

   // Pointers are exactly log2(DEPTH) bits, so truncation gives the modulo wrap.
   function automatic ptr_t ptr_add(input ptr_t p, input cnt_t off);
      return p + ptr_t'(off);
   endfunction

   function automatic cnt_t min_cnt(input cnt_t a, input cnt_t b);
      return (a < b) ? a : b;
   endfunction

   ibuf_entry_t mem [DEPTH];
   ptr_t        head;
   ptr_t        tail;
   cnt_t        eff_consume;
   cnt_t        free_slots;
   cnt_t        accepted;
   logic        write_excess;

   always_comb begin
      eff_consume  = min_cnt(cnt_t'(consume), count);
      free_slots   = cnt_t'(DEPTH) - count + eff_consume;
      accepted     = min_cnt(cnt_t'(in_count), free_slots);
      write_excess = cnt_t'(in_count) > free_slots;
   end

   assign in_ready = (count <= cnt_t'(READY_LIM));

   always_comb begin
      out_valid       = '0;
      out_pc          = '0;
      out_inst        = '0;
      out_pred_target = '0;
      out_pred_taken  = '0;
      out_have_exc    = '0;
      out_exc_type    = '0;
      for (int unsigned k = 0; k < OUT_WIDTH; k++) begin
         out_valid[k]       = count > cnt_t'(k);
         out_pc[k]          = mem[ptr_add(head, cnt_t'(k))].pc;
         out_inst[k]        = mem[ptr_add(head, cnt_t'(k))].inst;
         out_pred_target[k] = mem[ptr_add(head, cnt_t'(k))].pred_target;
         out_pred_taken[k]  = mem[ptr_add(head, cnt_t'(k))].pred_taken;
         out_have_exc[k]    = mem[ptr_add(head, cnt_t'(k))].have_exc;
         out_exc_type[k]    = mem[ptr_add(head, cnt_t'(k))].exc_type;
      end
      // Interrupt overrides only the presented lane 0; stored entry is untouched.
      if (interrupt) begin
         out_have_exc[0] = 1'b1;
         out_exc_type[0] = INT;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         tail  <= ptr_add(tail, accepted);
         head  <= ptr_add(head, eff_consume);
         count <= count + accepted - eff_consume;
         if (write_excess) overflow <= 1'b1;
      end
   end

   // Entry storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (!reset && !flush) begin
         for (int unsigned i = 0; i < IN_WIDTH; i++) begin
            if (cnt_t'(i) < accepted) begin
               mem[ptr_add(tail, cnt_t'(i))] <= '{
                  pc:          in_pc[i],
                  inst:        in_inst[i],
                  pred_taken:  in_pred_taken[i],
                  pred_target: in_pred_target[i],
                  have_exc:    in_have_exc[i],
                  exc_type:    in_exc_type[i]
               };
            end
         end
      end
   end

endmodule

// File: tb/tb_ibuf_multi.sv
// Self-checking bench for ibuf_multi: directed scenarios plus randomized traffic
// against a queue-based reference of the buffer contents.
module tb_ibuf_multi;
   import ibuf_multi_pkg::*;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned IW    = 2;
   localparam int unsigned OW    = 2;
   localparam int unsigned SKID  = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                        reset, flush, interrupt;
   logic [$clog2(IW+1)-1:0]     in_count;
   logic                        in_ready;
   logic [IW-1:0][31:0]         in_pc, in_inst, in_pred_target;
   logic [IW-1:0]               in_pred_taken, in_have_exc;
   exception_t [IW-1:0]         in_exc_type;
   logic [OW-1:0]               out_valid;
   logic [OW-1:0][31:0]         out_pc, out_inst, out_pred_target;
   logic [OW-1:0]               out_pred_taken, out_have_exc;
   exception_t [OW-1:0]         out_exc_type;
   logic [$clog2(OW+1)-1:0]     consume;
   logic [$clog2(DEPTH+1)-1:0]  count;
   logic                        overflow;

   ibuf_multi #(.DEPTH(DEPTH), .IN_WIDTH(IW), .OUT_WIDTH(OW), .SKID(SKID)) dut (
      .clk(clk), .reset(reset), .flush(flush), .interrupt(interrupt),
      .in_count(in_count), .in_ready(in_ready),
      .in_pc(in_pc), .in_inst(in_inst), .in_pred_target(in_pred_target),
      .in_pred_taken(in_pred_taken), .in_have_exc(in_have_exc), .in_exc_type(in_exc_type),
      .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
      .out_pred_target(out_pred_target), .out_pred_taken(out_pred_taken),
      .out_have_exc(out_have_exc), .out_exc_type(out_exc_type),
      .consume(consume), .count(count), .overflow(overflow)
   );

   int          checks = 0;
   int          errors = 0;
   ibuf_entry_t q[$];
   logic        ovf_m = 1'b0;

   function automatic ibuf_entry_t rand_entry();
      ibuf_entry_t e;
      e.pc          = $urandom;
      e.inst        = $urandom;
      e.pred_taken  = 1'($urandom_range(0, 1));
      e.pred_target = $urandom;
      e.have_exc    = 1'($urandom_range(0, 1));
      e.exc_type    = exception_t'(4'($urandom_range(0, 7)));
      return e;
   endfunction

   task automatic set_lane(input int i, input ibuf_entry_t e);
      in_pc[i]          = e.pc;
      in_inst[i]        = e.inst;
      in_pred_taken[i]  = e.pred_taken;
      in_pred_target[i] = e.pred_target;
      in_have_exc[i]    = e.have_exc;
      in_exc_type[i]    = e.exc_type;
   endtask

   task automatic rand_lanes();
      for (int i = 0; i < IW; i++) set_lane(i, rand_entry());
   endtask

   function automatic ibuf_entry_t in_lane(input int i);
      return '{pc: in_pc[i], inst: in_inst[i], pred_taken: in_pred_taken[i],
               pred_target: in_pred_target[i], have_exc: in_have_exc[i],
               exc_type: in_exc_type[i]};
   endfunction

   function automatic ibuf_entry_t out_lane(input int k);
      return '{pc: out_pc[k], inst: out_inst[k], pred_taken: out_pred_taken[k],
               pred_target: out_pred_target[k], have_exc: out_have_exc[k],
               exc_type: out_exc_type[k]};
   endfunction

   task automatic drive_idle();
      reset = 1'b0; flush = 1'b0; interrupt = 1'b0;
      in_count = '0; consume = '0;
   endtask

   // Reference: occupancy is the queue length; consume pops, accepted lanes push.
   task automatic tick();
      int eff;
      int free;
      @(posedge clk);
      if (reset) begin
         q.delete();
         ovf_m = 1'b0;
      end else if (flush) begin
         q.delete();
      end else begin
         eff = (int'(consume) > q.size()) ? q.size() : int'(consume);
         repeat (eff) void'(q.pop_front());
         free = DEPTH - q.size();
         if (int'(in_count) > free) ovf_m = 1'b1;
         for (int i = 0; i < int'(in_count) && i < free; i++) q.push_back(in_lane(i));
      end
      #1;
   endtask

   task automatic do_reset();
      drive_idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (count !== 0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL reset_valid got=%b exp=00", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
   endtask

   task automatic test_basic();
      do_reset();
      rand_lanes();
      in_pc[0] = 32'h1c000000;
      in_pc[1] = 32'h1c000004;
      in_count = 2;
      tick();
      in_count = 0;
      checks++; if (out_valid !== 2'b11) begin errors++; $display("FAIL basic_valid got=%b exp=11", out_valid); end
      checks++; if (out_pc[0] !== 32'h1c000000) begin errors++; $display("FAIL basic_pc0 got=%h exp=1c000000", out_pc[0]); end
      checks++; if (out_pc[1] !== 32'h1c000004) begin errors++; $display("FAIL basic_pc1 got=%h exp=1c000004", out_pc[1]); end
      checks++; if (count !== 2) begin errors++; $display("FAIL basic_count got=%0d exp=2", count); end
   endtask

   task automatic test_fill_overflow();
      do_reset();
      for (int c = 0; c < 6; c++) begin rand_lanes(); in_count = 2; tick(); end
      checks++; if (count !== 12 || in_ready !== 1'b1) begin errors++; $display("FAIL ready_at12 count=%0d ready=%b exp=12/1", count, in_ready); end
      rand_lanes(); in_count = 1; tick();
      checks++; if (count !== 13 || in_ready !== 1'b0) begin errors++; $display("FAIL ready_at13 count=%0d ready=%b exp=13/0", count, in_ready); end
      rand_lanes(); in_count = 2; tick();
      rand_lanes(); in_count = 1; tick();
      checks++; if (count !== 16 || overflow !== 1'b0) begin errors++; $display("FAIL full count=%0d ovf=%b exp=16/0", count, overflow); end
      rand_lanes(); in_count = 2; tick();
      checks++; if (count !== 16 || overflow !== 1'b1) begin errors++; $display("FAIL overflow count=%0d ovf=%b exp=16/1", count, overflow); end
      rand_lanes(); in_count = 2; consume = 2; tick();
      consume = 0; in_count = 0;
      checks++; if (count !== 16) begin errors++; $display("FAIL full_swap count=%0d exp=16", count); end
      checks++; if (out_lane(0) !== q[0] || out_lane(1) !== q[1]) begin errors++; $display("FAIL full_swap_data got=%h exp=%h", out_lane(0), q[0]); end
      rand_lanes(); flush = 1'b1; in_count = 2; consume = 2; tick();
      drive_idle();
      checks++; if (count !== 0 || out_valid !== 2'b00 || overflow !== 1'b1) begin errors++; $display("FAIL flush count=%0d valid=%b ovf=%b exp=0/00/1", count, out_valid, overflow); end
      do_reset();
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_clears_ovf got=%b exp=0", overflow); end
   endtask

   task automatic test_wrap_underflow();
      ibuf_entry_t a, b;
      do_reset();
      for (int c = 0; c < 15; c++) begin rand_lanes(); in_count = 1; consume = 1; tick(); end
      in_count = 0; consume = 1; tick();
      checks++; if (count !== 0) begin errors++; $display("FAIL wrap_prep count=%0d exp=0", count); end
      a = rand_entry(); b = rand_entry();
      set_lane(0, a); set_lane(1, b); in_count = 2; consume = 0; tick();
      in_count = 0;
      checks++; if (out_lane(0) !== a || out_lane(1) !== b || count !== 2) begin errors++; $display("FAIL wrap_pair got=%h/%h exp=%h/%h", out_pc[0], out_pc[1], a.pc, b.pc); end
      consume = 1; tick();
      checks++; if (out_lane(0) !== b || count !== 1) begin errors++; $display("FAIL wrap_second got=%h exp=%h", out_pc[0], b.pc); end
      consume = 2; tick();
      consume = 0;
      checks++; if (count !== 0 || out_valid !== 2'b00 || overflow !== 1'b0) begin errors++; $display("FAIL underflow count=%0d valid=%b ovf=%b exp=0/00/0", count, out_valid, overflow); end
      a = rand_entry(); b = rand_entry();
      set_lane(0, a); set_lane(1, b); in_count = 2; tick();
      in_count = 0;
      checks++; if (out_lane(0) !== a || out_lane(1) !== b) begin errors++; $display("FAIL underflow_head got=%h exp=%h", out_pc[0], a.pc); end
   endtask

   task automatic test_interrupt();
      ibuf_entry_t a, b;
      do_reset();
      a = rand_entry(); a.have_exc = 1'b1; a.exc_type = ADEF;
      b = rand_entry(); b.have_exc = 1'b1; b.exc_type = ALE;
      set_lane(0, a); set_lane(1, b); in_count = 2; tick();
      in_count = 0; interrupt = 1'b1; #1;
      checks++; if (out_exc_type[0] !== INT || out_have_exc[0] !== 1'b1) begin errors++; $display("FAIL int_lane0 got=%0d/%b exp=%0d/1", out_exc_type[0], out_have_exc[0], INT); end
      checks++; if (out_lane(1) !== b || out_pc[0] !== a.pc) begin errors++; $display("FAIL int_lane1 got=%h exp=%h", out_lane(1), b); end
      tick();
      interrupt = 1'b0; #1;
      checks++; if (count !== 2 || out_lane(0) !== a) begin errors++; $display("FAIL int_state count=%0d lane0=%h exp=2/%h", count, out_lane(0), a); end
   endtask

   task automatic test_random();
      ibuf_entry_t exp_l;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         rand_lanes();
         if ((c / 50) % 2 == 0) begin
            in_count = 2'($urandom_range(0, 2)); consume = 2'($urandom_range(0, 1));
         end else begin
            in_count = 2'($urandom_range(0, 1)); consume = 2'($urandom_range(0, 2));
         end
         flush     = ($urandom_range(0, 39) == 0);
         interrupt = 1'($urandom_range(0, 1));
         tick();
         checks++; if (count !== q.size()) begin errors++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", c, count, q.size()); end
         checks++; if (overflow !== ovf_m) begin errors++; $display("FAIL rnd_overflow cyc=%0d got=%b exp=%b", c, overflow, ovf_m); end
         checks++; if (in_ready !== (q.size() <= DEPTH - IW * (SKID + 1))) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b size=%0d", c, in_ready, q.size()); end
         for (int k = 0; k < OW; k++) begin
            checks++; if (out_valid[k] !== (q.size() > k)) begin errors++; $display("FAIL rnd_valid cyc=%0d lane=%0d got=%b size=%0d", c, k, out_valid[k], q.size()); end
            if (q.size() > k) begin
               exp_l = q[k];
               if (k == 0 && interrupt) begin exp_l.have_exc = 1'b1; exp_l.exc_type = INT; end
               checks++; if (out_lane(k) !== exp_l) begin errors++; $display("FAIL rnd_data cyc=%0d lane=%0d got=%h exp=%h", c, k, out_lane(k), exp_l); end
            end
         end
      end
      drive_idle();
   endtask

   initial begin
      drive_idle();
      in_pc = '0; in_inst = '0; in_pred_target = '0;
      in_pred_taken = '0; in_have_exc = '0; in_exc_type = '0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_fill_overflow();
      test_wrap_underflow();
      test_interrupt();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete within time limit");
      $fatal(1, "timeout");
   end

endmodule
